// File: rtl/eth_rx_pkt_buffer_if.sv
// Port bundle for eth_rx_pkt_buffer: ingress word stream, committed-word read side and drop statistics.
// The buffer uses the slave modport; the port/fabric side uses master.
interface eth_rx_pkt_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_start;
    logic              i_end;
    logic              rd_en;
    logic [DATA_W+1:0] rd_data;
    logic              rd_empty;
    logic [PW-1:0]     pkt_count;
    logic              drop;
    logic [15:0]       drop_count;

    modport master (
        output i_valid, i_data, i_start, i_end, rd_en,
        input  rd_data, rd_empty, pkt_count, drop, drop_count
    );

    modport slave (
        input  i_valid, i_data, i_start, i_end, rd_en,
        output rd_data, rd_empty, pkt_count, drop, drop_count
    );
endinterface

// File: rtl/eth_rx_pkt_buffer.sv
// Ethernet receive packet buffer: words are written tentatively and only committed on a clean end-of-packet.
// Define ETH_RX_STATS_EN to build the saturating 16-bit drop_count; otherwise drop_count is tied to 0.
module eth_rx_pkt_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int MAX_WORDS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_rx_pkt_buffer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, RX, DROP} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     tmpPtr_q, tmpPtr_d;
    logic [PW-1:0]     wordCnt_q, wordCnt_d;
    logic [PW-1:0]     pktCount_q, pktCount_d;
    logic              drop_q, drop_d;

    logic [DATA_W+1:0] mem [DEPTH];
    logic [DATA_W+1:0] headWord;
    logic [DATA_W+1:0] wrWord;
    logic              memWe;
    logic [PW-1:0]     memPtr;

    logic              full;
    logic              roomAtCommit;
    logic              rdEmpty;
    logic              pop;
    logic              popEnd;
    logic              commit;
    logic              truncDrop;
    logic              newDrop;
    logic [1:0]        dropInc;

    assign headWord     = mem[rdPtr_q[AW-1:0]];
    assign wrWord       = {bus.i_end, bus.i_start, bus.i_data};
    assign rdEmpty      = (rdPtr_q == wrPtr_q);
    assign full         = ((tmpPtr_q - rdPtr_q) == PW'(DEPTH));
    // A new start always restarts from the committed pointer, so its room check ignores tentative words.
    assign roomAtCommit = ((wrPtr_q - rdPtr_q) != PW'(DEPTH));
    assign pop          = bus.rd_en && !rdEmpty;
    assign popEnd       = pop && headWord[DATA_W+1];
    assign dropInc      = {truncDrop & newDrop, truncDrop ^ newDrop};

    always_comb begin
        state_d    = state_q;
        tmpPtr_d   = tmpPtr_q;
        wrPtr_d    = wrPtr_q;
        wordCnt_d  = wordCnt_q;
        memWe      = 1'b0;
        memPtr     = tmpPtr_q;
        commit     = 1'b0;
        truncDrop  = 1'b0;
        newDrop    = 1'b0;

        if (bus.i_valid) begin
            if (bus.i_start) begin
                truncDrop = (state_q == RX);
                tmpPtr_d  = wrPtr_q;
                if (roomAtCommit) begin
                    memWe     = 1'b1;
                    memPtr    = wrPtr_q;
                    wordCnt_d = PW'(1);
                    tmpPtr_d  = wrPtr_q + PW'(1);
                    if (bus.i_end) begin
                        wrPtr_d = wrPtr_q + PW'(1);
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RX;
                    end
                end else begin
                    newDrop = 1'b1;
                    state_d = bus.i_end ? IDLE : DROP;
                end
            end else if (state_q == RX) begin
                if (full || (wordCnt_q == PW'(MAX_WORDS))) begin
                    tmpPtr_d = wrPtr_q;
                    newDrop  = 1'b1;
                    state_d  = bus.i_end ? IDLE : DROP;
                end else begin
                    memWe     = 1'b1;
                    memPtr    = tmpPtr_q;
                    tmpPtr_d  = tmpPtr_q + PW'(1);
                    wordCnt_d = wordCnt_q + PW'(1);
                    if (bus.i_end) begin
                        wrPtr_d = tmpPtr_q + PW'(1);
                        commit  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end else if ((state_q == DROP) && bus.i_end) begin
                state_d = IDLE;
            end
        end

        rdPtr_d    = pop ? rdPtr_q + PW'(1) : rdPtr_q;
        pktCount_d = pktCount_q + PW'(commit) - PW'(popEnd);
        drop_d     = (dropInc != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            tmpPtr_q   <= '0;
            wordCnt_q  <= '0;
            pktCount_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            tmpPtr_q   <= tmpPtr_d;
            wordCnt_q  <= wordCnt_d;
            pktCount_q <= pktCount_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memPtr[AW-1:0]] <= wrWord;
        end
    end

`ifdef ETH_RX_STATS_EN
    logic [15:0] dropCount_q;
    logic [16:0] dropSum;

    assign dropSum = {1'b0, dropCount_q} + 17'(dropInc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCount_q <= '0;
        end else if (dropInc != 2'd0) begin
            dropCount_q <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
        end
    end

    assign bus.drop_count = dropCount_q;
`else
    assign bus.drop_count = 16'h0000;
`endif

    assign bus.rd_data   = headWord;
    assign bus.rd_empty  = rdEmpty;
    assign bus.pkt_count = pktCount_q;
    assign bus.drop      = drop_q;
endmodule
